// File: rtl/mem_rsp_pkg.sv
// Shared definitions for the data memory responder: FSM encoding and word geometry.
package mem_rsp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_LSB   = 2;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with synchronous byte-enabled write and registered read.
module mem_array
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [WORD_BYTES-1:0]     be,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [8*WORD_BYTES-1:0]   wdata,
  input  logic                      re,
  output logic [8*WORD_BYTES-1:0]   rdata
);

  logic [8*WORD_BYTES-1:0] mem [DEPTH_WORDS];

  // No reset: contents survive responder reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Request/response memory slave: accepts one request, waits WAIT_STATES cycles, then
// performs the access and holds the response until the initiator takes it.
module data_mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_we_q;
  logic [31:0] cap_addr_q, cap_wdata_q;
  logic [3:0]  cap_be_q;
  logic        err_q, err_d;
  logic        rd_q, rd_d;

  logic        accept, enter_resp, fault;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;

  assign req_ready = (state_q == StIdle) && !rst_in;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the acceptance edge, so use live inputs.
  always_comb begin
    acc_we    = cap_we_q;
    acc_addr  = cap_addr_q;
    acc_wdata = cap_wdata_q;
    acc_be    = cap_be_q;
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign fault = (acc_addr[ADDR_LSB-1:0] != '0) ||
                 ({2'b00, acc_addr[31:ADDR_LSB]} >= DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rd_d       = rd_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          err_d   = 1'b0;
          rd_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      err_d = fault;
      rd_d  = !acc_we && !fault;
    end
  end

  // Reset on the entry edge discards the pending access.
  assign mem_we = enter_resp && acc_we && !fault && !rst_in;
  assign mem_re = enter_resp && !acc_we && !fault && !rst_in;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_be_q    <= '0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      if (accept) begin
        cap_we_q    <= req_we;
        cap_addr_q  <= req_addr;
        cap_wdata_q <= req_wdata;
        cap_be_q    <= req_be;
      end
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (acc_be),
    .addr  (acc_addr[ADDR_LSB +: AW]),
    .wdata (acc_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && rd_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: main instance with 2 wait states, second instance with 0 wait states.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_in, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_rst_in, z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int passes = 0;
  int total  = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_z (
    .clk       (clk),
    .rst_in    (z_rst_in),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_we    (z_req_we),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_be    (z_req_be),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (z_rsp_ready),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the main instance; lat counts cycles from the acceptance cycle
  // (cycle 0) to the first cycle with rsp_valid high.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    rdata     = rsp_rdata;
    err       = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst_in = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0;
    z_rst_in = 1'b1; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0;
    z_req_wdata = '0; z_req_be = '0; z_rsp_ready = 1'b0;
    step();
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    step();
    rst_in = 1'b0; z_rst_in = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("valid_after_reset", 32'(rsp_valid), 32'd0);
    chk("rdata_after_reset", rsp_rdata, 32'd0);
    chk("err_after_reset", 32'(rsp_err), 32'd0);

    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(1'b1, 32'h20, 32'h000000AA, 4'h1, rd, er, lat);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("byte_lane0", rd, 32'h112233AA);
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("be0_err", 32'(er), 32'd0);
    chk("be0_rdata", rd, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("be0_noop", rd, 32'h112233AA);

    txn(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    txn(1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat);
    chk("oob_err", 32'(er), 32'd1);
    chk("oob_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    chk("addr0_intact", rd, 32'hCAFEF00D);
    txn(1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    chk("last_word_err", 32'(er), 32'd0);
    txn(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
    chk("last_word_data", rd, 32'hA5A5A5A5);

    // Backpressure: read 0x10, hold rsp_ready low; a write offered meanwhile must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    step();
    req_we = 1'b1; req_wdata = 32'h0;
    step();
    step();
    chk("bp_valid_rise", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_hold_err", 32'(rsp_err), 32'd0);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_released_rdata", rsp_rdata, 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("bp_ignored_req", rd, 32'hDEADBEEF);

    // Reset in the last WAIT cycle of a write to 0x8.
    txn(1'b1, 32'h8, 32'h77777777, 4'hF, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    rst_in = 1'b1;
    #1;
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    step();
    rst_in = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rst_no_response", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    chk("rst_write_discarded", rd, 32'h77777777);

    // Zero wait states: back-to-back with rsp_ready held high.
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h4; z_req_wdata = 32'h0BADCAFE;
    z_req_be = 4'hF;
    chk("z_c0_ready", 32'(z_req_ready), 32'd1);
    step();
    chk("z_c1_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_c1_ready", 32'(z_req_ready), 32'd0);
    chk("z_c1_err", 32'(z_rsp_err), 32'd0);
    z_req_we = 1'b0;
    step();
    chk("z_c2_valid", 32'(z_rsp_valid), 32'd0);
    chk("z_c2_ready", 32'(z_req_ready), 32'd1);
    step();
    chk("z_c3_valid", 32'(z_rsp_valid), 32'd1);
    chk("z_c3_rdata", z_rsp_rdata, 32'h0BADCAFE);
    z_req_valid = 1'b0;
    step();
    chk("z_c4_valid", 32'(z_rsp_valid), 32'd0);
    chk("z_c4_rdata", z_rsp_rdata, 32'd0);
    chk("z_c4_ready", 32'(z_req_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words; it SHALL be a power of two, at least 4.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, giving the added response latency in cycles; legal range is 0..15.
REQ-003 The ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder accepts a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte-lane write enables; bit i controls bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  request faulted.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL be 1 if and only if the state is IDLE and rst_in is 0.
REQ-006 Acceptance SHALL occur on an edge where req_valid and req_ready are both 1; req_we, req_addr, req_wdata and req_be SHALL be captured on that edge.
REQ-007 On acceptance, the state SHALL go to WAIT with the counter loaded to WAIT_STATES-1 when WAIT_STATES>0; otherwise it SHALL go directly to RESP.
REQ-008 In WAIT, the counter SHALL decrement each cycle; when it is 0, the next state SHALL be RESP.
REQ-009 rsp_valid SHALL rise exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-010 The memory access (read sample or byte-enabled write) SHALL take place on the edge that enters RESP.
REQ-011 A request SHALL fault if req_addr[1:0]!=0 or word index req_addr>>2 >= DEPTH_WORDS.
REQ-012 A faulting request SHALL not write memory and SHALL return rsp_err=1 with rsp_rdata=0.
REQ-013 A read SHALL return the full word regardless of req_be.
REQ-014 A write with req_be=0 SHALL be a legal no-op, returning rsp_err=0 and rsp_rdata=0.
REQ-015 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready=1; the state SHALL then return to IDLE.
REQ-016 No request SHALL be accepted on the response-handshake edge, so the minimum spacing between acceptances is WAIT_STATES+2 cycles.
REQ-017 Request inputs SHALL be ignored outside IDLE.
REQ-018 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-019 When rst_in=1 at an edge, the state SHALL become IDLE, the counter 0, and the captured request and response registers 0, including mid-transaction; any pending write not yet performed SHALL be discarded.
REQ-020 Outputs after reset SHALL be rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL be 0 during reset and 1 on the first cycle after it.
REQ-021 Memory contents SHALL not be cleared by reset.

Structure
REQ-022 A shared package mem_rsp_pkg SHALL hold the state encoding (IDLE/WAIT/RESP), WORD_BYTES=4 and ADDR_LSB=2.
REQ-023 The storage SHALL be one sub-module, mem_array: a DEPTH_WORDS x 32 array with synchronous byte-enabled write and registered read; the FSM stays in data_mem_responder.

Verification
REQ-024 Write then read, WAIT_STATES=2: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> each rsp_valid rises 3 cycles after acceptance; the read returns 0xDEADBEEF with err=0.
REQ-025 Byte lanes: with 0x11223344 stored at 0x20, write 0x000000AA with be=0x1 -> a read returns 0x112233AA.
REQ-026 Faults: read 0x12 (misaligned) and write to 0x400 with DEPTH_WORDS=256 -> both give err=1 and rdata=0, and memory at 0x0 is unchanged.
REQ-027 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable and req_ready=0; the state returns to IDLE one cycle after rsp_ready=1.
REQ-028 Reset mid-WAIT: assert rst_in for 1 cycle during WAIT of a write of 0x55 to 0x8 -> no response is produced, memory at 0x8 is unchanged, and req_ready=1 the next cycle.
REQ-029 WAIT_STATES=0: a read is accepted and rsp_valid rises 1 cycle later; back-to-back requests with rsp_ready=1 are accepted every 2 cycles.
